// File: rtl/eq_band_mixer_pkg.sv
// Shared constants and types for the equalizer band mixer.
// Gain format is Q2.6 unsigned; output limits follow the default 24-bit sample width.
package eq_mixer_pkg;

  localparam int GAIN_UNITY = 64;
  localparam int GAIN_FRAC  = 6;
  localparam int OUT_W_DEF  = 24;

  localparam logic signed [OUT_W_DEF-1:0] SAT_MAX = {1'b0, {(OUT_W_DEF-1){1'b1}}};
  localparam logic signed [OUT_W_DEF-1:0] SAT_MIN = {1'b1, {(OUT_W_DEF-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    SCALE = 2'd2,
    OUT   = 2'd3
  } eq_state_t;

endpackage

// File: rtl/eq_band_mixer_if.sv
// Filter-bank result input and stereo sample output of the band mixer.
// The master side feeds band results and consumes mixed samples; the mixer is the slave.
interface eq_band_mixer_if #(
  parameter int NUM_BANDS = 4,
  parameter int OUT_W     = 24
);

  logic                        in_valid;
  logic [NUM_BANDS-1:0][47:0]  l_band_in;
  logic [NUM_BANDS-1:0][47:0]  r_band_in;
  logic signed [OUT_W-1:0]     l_data_out;
  logic signed [OUT_W-1:0]     r_data_out;
  logic                        out_valid;
  logic                        busy;

  modport master (
    output in_valid, l_band_in, r_band_in,
    input  l_data_out, r_data_out, out_valid, busy
  );

  modport slave (
    input  in_valid, l_band_in, r_band_in,
    output l_data_out, r_data_out, out_valid, busy
  );

endinterface

// File: rtl/eq_band_mixer_sat_narrow.sv
// Combinational saturating narrower: clamps a signed value to OUT_W bits
// and flags when clamping happened.
module sat_narrow #(
  parameter int IN_W  = 38,
  parameter int OUT_W = 24
) (
  input  logic signed [IN_W-1:0]  in_data,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    ovf
);

  // Fits only if every bit above the output sign bit matches it.
  logic [IN_W-OUT_W:0] hi_bits;

  assign hi_bits  = in_data[IN_W-1:OUT_W-1];
  assign ovf      = !((&hi_bits) || (~|hi_bits));
  assign out_data = !ovf ? in_data[OUT_W-1:0]
                  : in_data[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                  : {1'b0, {(OUT_W-1){1'b1}}};

endmodule

// File: rtl/eq_band_mixer.sv
// Per-band gain and stereo sum of FIR equalizer results, rescaled and saturated
// to one stereo sample per filter-bank strobe.
//
//   state | meaning
//   IDLE  | waiting for in_valid; snapshot band data and gains on arrival
//   ACCUM | one band per clk multiplied by its gain and accumulated (L and R)
//   SCALE | drop gain fraction, saturate or mute, register the sample
//   OUT   | out_valid strobe; busy drops after this cycle
module eq_band_mixer
  import eq_mixer_pkg::*;
#(
  parameter int NUM_BANDS = 4,
  parameter int COEF_FRAC = 15,
  parameter int GAIN_W    = 8,
  parameter int OUT_W     = OUT_W_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              audio_en,
  eq_band_mixer_if.slave    mix,
  input  logic              gain_wr_en,
  input  logic [5:0]        gain_sel,
  input  logic [GAIN_W-1:0] gain_wr_data,
  input  logic              mute,
  input  logic              sat_clr,
  output logic              sat_flag,
  output logic              overrun_flag
);

  localparam int B_W   = 48 - COEF_FRAC;
  localparam int P_W   = B_W + GAIN_W + 1;
  localparam int ACC_W = P_W + $clog2(NUM_BANDS);
  localparam int RES_W = ACC_W - GAIN_FRAC;
  localparam int IDX_W = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;

  eq_state_t                       state_q, state_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic [NUM_BANDS-1:0][47:0]      l_snap_q, l_snap_d, r_snap_q, r_snap_d;
  logic [NUM_BANDS-1:0][GAIN_W-1:0] gain_q, gain_d, gain_snap_q, gain_snap_d;
  logic signed [ACC_W-1:0]         l_acc_q, l_acc_d, r_acc_q, r_acc_d;
  logic signed [OUT_W-1:0]         l_out_q, l_out_d, r_out_q, r_out_d;
  logic                            out_valid_q, out_valid_d;
  logic                            busy_q, busy_d;
  logic                            sat_q, sat_d, ovr_q, ovr_d;
  logic                            sat_set;

  logic signed [B_W-1:0]    l_b, r_b;
  logic signed [GAIN_W:0]   g_s;
  logic signed [P_W-1:0]    l_p, r_p;
  logic signed [RES_W-1:0]  l_res, r_res;
  logic signed [OUT_W-1:0]  l_sat, r_sat;
  logic                     l_ovf, r_ovf;

  // Taking the upper bits is the arithmetic shift by COEF_FRAC.
  assign l_b = l_snap_q[idx_q][47:COEF_FRAC];
  assign r_b = r_snap_q[idx_q][47:COEF_FRAC];
  assign g_s = {1'b0, gain_snap_q[idx_q]};
  assign l_p = P_W'(l_b) * P_W'(g_s);
  assign r_p = P_W'(r_b) * P_W'(g_s);

  assign l_res = l_acc_q[ACC_W-1:GAIN_FRAC];
  assign r_res = r_acc_q[ACC_W-1:GAIN_FRAC];

  sat_narrow #(.IN_W(RES_W), .OUT_W(OUT_W)) u_sat_l (
    .in_data (l_res),
    .out_data(l_sat),
    .ovf     (l_ovf)
  );

  sat_narrow #(.IN_W(RES_W), .OUT_W(OUT_W)) u_sat_r (
    .in_data (r_res),
    .out_data(r_sat),
    .ovf     (r_ovf)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    l_snap_d    = l_snap_q;
    r_snap_d    = r_snap_q;
    gain_snap_d = gain_snap_q;
    gain_d      = gain_q;
    l_acc_d     = l_acc_q;
    r_acc_d     = r_acc_q;
    l_out_d     = l_out_q;
    r_out_d     = r_out_q;
    out_valid_d = 1'b0;
    busy_d      = busy_q;
    sat_set     = 1'b0;

    for (int i = 0; i < NUM_BANDS; i++) begin
      if (gain_wr_en && (int'(gain_sel) == i)) gain_d[i] = gain_wr_data;
    end

    unique case (state_q)
      IDLE: begin
        if (mix.in_valid) begin
          l_snap_d    = mix.l_band_in;
          r_snap_d    = mix.r_band_in;
          gain_snap_d = gain_q;
          l_acc_d     = '0;
          r_acc_d     = '0;
          idx_d       = '0;
          busy_d      = 1'b1;
          state_d     = ACCUM;
        end
      end
      ACCUM: begin
        l_acc_d = l_acc_q + ACC_W'(l_p);
        r_acc_d = r_acc_q + ACC_W'(r_p);
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(NUM_BANDS - 1)) state_d = SCALE;
      end
      SCALE: begin
        l_out_d     = mute ? '0 : l_sat;
        r_out_d     = mute ? '0 : r_sat;
        sat_set     = !mute && (l_ovf || r_ovf);
        out_valid_d = 1'b1;
        state_d     = OUT;
      end
      OUT: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // A new flag event in the clearing cycle survives the clear.
    sat_d = (sat_q & ~sat_clr) | sat_set;
    ovr_d = (ovr_q & ~sat_clr) | (mix.in_valid & busy_q);

    if (!audio_en) begin
      state_d     = IDLE;
      idx_d       = '0;
      l_acc_d     = '0;
      r_acc_d     = '0;
      l_out_d     = '0;
      r_out_d     = '0;
      out_valid_d = 1'b0;
      busy_d      = 1'b0;
      sat_d       = 1'b0;
      ovr_d       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      l_snap_q    <= '0;
      r_snap_q    <= '0;
      gain_snap_q <= '0;
      for (int i = 0; i < NUM_BANDS; i++) gain_q[i] <= GAIN_W'(GAIN_UNITY);
      l_acc_q     <= '0;
      r_acc_q     <= '0;
      l_out_q     <= '0;
      r_out_q     <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      sat_q       <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      l_snap_q    <= l_snap_d;
      r_snap_q    <= r_snap_d;
      gain_snap_q <= gain_snap_d;
      gain_q      <= gain_d;
      l_acc_q     <= l_acc_d;
      r_acc_q     <= r_acc_d;
      l_out_q     <= l_out_d;
      r_out_q     <= r_out_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      sat_q       <= sat_d;
      ovr_q       <= ovr_d;
    end
  end

  assign mix.l_data_out = l_out_q;
  assign mix.r_data_out = r_out_q;
  assign mix.out_valid  = out_valid_q;
  assign mix.busy       = busy_q;
  assign sat_flag       = sat_q;
  assign overrun_flag   = ovr_q;

endmodule
